// File: rtl/bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_timer
//  Description : BCD stopwatch counter M..M.SS.D driven by a 0.1 s prescaler.
//                Counts up or down with preset load, configurable minute
//                digits, wrap or stop-at-limit behaviour, a done pulse and a
//                lap-capture register. Nibble 0 is tenths, nibble 1 seconds,
//                nibble 2 tens of seconds, nibbles 3.. minutes.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_timer #(
   parameter int DVSR       = 10_000_000,  // clk cycles per 0.1 s tick (>= 2)
   parameter int MIN_DIGITS = 1,           // minute digits, 1 or 2
   parameter int WRAP       = 1,           // 1 = wrap at limit, 0 = stop
   localparam int ND        = 3 + MIN_DIGITS,
   localparam int W         = 4 * ND
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         go,
   input  logic         clr,
   input  logic         load,
   input  logic [W-1:0] preset,
   input  logic         up,
   input  logic         lap,
   output logic [W-1:0] digits,
   output logic [W-1:0] lap_digits,
   output logic         lap_valid,
   output logic         done,
   output logic         running
);

   // ------------------------------------------------------------------------
   // Constants
   // ------------------------------------------------------------------------
   localparam int             PW           = (DVSR > 2) ? $clog2(DVSR) : 1;
   localparam logic [PW-1:0]  C_PRESC_LAST = PW'(DVSR - 1);
   localparam logic [PW-1:0]  C_PRESC_ONE  = PW'(1);
   localparam logic           C_STOP_MODE  = (WRAP == 0);

   localparam logic [1:0]     C_IDLE       = 2'd0;
   localparam logic [1:0]     C_RUN        = 2'd1;
   localparam logic [1:0]     C_EXPIRED    = 2'd2;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   logic [1:0]    r_state;
   logic [PW-1:0] r_presc;
   logic [W-1:0]  r_digits;
   logic [W-1:0]  r_lap_digits;
   logic          r_lap_valid;
   logic          r_done;
   logic          r_running;

   // ------------------------------------------------------------------------
   // Combinational nets
   // ------------------------------------------------------------------------
   logic [1:0]    w_state_nxt;
   logic          w_run_en;        // FSM currently in RUN
   logic          w_running_nxt;   // running flag for the next cycle
   logic          w_tick;          // prescaler at end of its period
   logic          w_tick_eff;      // tick not overridden by clr/load
   logic [ND-1:0] w_up_roll;       // digit sits at its top value
   logic [ND-1:0] w_dn_roll;       // digit sits at zero
   logic [ND-1:0] w_up_step;       // digit advances on an up tick
   logic [ND-1:0] w_dn_step;       // digit retreats on a down tick
   logic [W-1:0]  w_cnt_up;        // count after one up step
   logic [W-1:0]  w_cnt_dn;        // count after one down step
   logic [W-1:0]  w_cnt_nxt;       // count after one step in current direction
   logic [W-1:0]  w_max;           // all-digits-at-limit value
   logic [W-1:0]  w_term;          // terminal value for current direction
   logic [W-1:0]  w_preset_s;      // preset clamped to legal BCD per digit
   logic          w_at_term;       // count already at terminal value
   logic          w_nxt_term;      // next step lands on terminal value
   logic          w_term_evt;      // terminal event on this edge
   logic          w_cnt_step;      // count register takes w_cnt_nxt

   // ------------------------------------------------------------------------
   // Per-digit stepping and preset clamping. Tens of seconds is mod-6, every
   // other digit mod-10. A digit moves only when every lower digit is at its
   // roll value for the current direction, so MAX+1 rolls to MIN and MIN-1
   // rolls to MAX with no extra logic.
   // ------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < ND; gi++) begin : g_digit
         localparam logic [3:0] C_LIM = (gi == 2) ? 4'd5 : 4'd9;

         logic [3:0] w_cur;
         logic [3:0] w_pre;

         assign w_cur                = r_digits[4*gi +: 4];
         assign w_pre                = preset[4*gi +: 4];
         assign w_max[4*gi +: 4]     = C_LIM;
         assign w_up_roll[gi]        = (w_cur == C_LIM);
         assign w_dn_roll[gi]        = (w_cur == 4'd0);
         assign w_preset_s[4*gi +: 4] = (w_pre > C_LIM) ? C_LIM : w_pre;

         if (gi == 0) begin : g_lsd
            assign w_up_step[gi] = 1'b1;
            assign w_dn_step[gi] = 1'b1;
         end else begin : g_upper
            assign w_up_step[gi] = &w_up_roll[gi-1:0];
            assign w_dn_step[gi] = &w_dn_roll[gi-1:0];
         end

         assign w_cnt_up[4*gi +: 4] = !w_up_step[gi] ? w_cur :
                                      (w_up_roll[gi] ? 4'd0 : w_cur + 4'd1);
         assign w_cnt_dn[4*gi +: 4] = !w_dn_step[gi] ? w_cur :
                                      (w_dn_roll[gi] ? C_LIM : w_cur - 4'd1);
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Direction select, terminal detection and tick qualification. The
   // direction is sampled on the tick edge itself, so a change of `up`
   // between ticks simply picks the other step on the next tick.
   // ------------------------------------------------------------------------
   assign w_cnt_nxt  = up ? w_cnt_up : w_cnt_dn;
   assign w_term     = up ? w_max : '0;
   assign w_at_term  = (r_digits == w_term);
   assign w_nxt_term = (w_cnt_nxt == w_term);

   assign w_tick     = w_run_en && (r_presc == C_PRESC_LAST);
   assign w_tick_eff = w_tick && !clr && !load;

   // Wrap mode: only stepping off the terminal value counts as the event.
   // Stop mode: landing on it, or ticking while already there, counts.
   assign w_term_evt = C_STOP_MODE ? (w_tick_eff && (w_at_term || w_nxt_term))
                                   : (w_tick_eff && w_at_term);

   // In stop mode a tick at the terminal value leaves the count untouched.
   assign w_cnt_step = w_tick_eff && !(C_STOP_MODE && w_at_term);

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= C_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state logic: clr/load force IDLE, EXPIRED waits for them
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      if (clr || load) begin
         w_state_nxt = C_IDLE;
      end else begin
         case (r_state)
            C_IDLE: begin
               if (go) w_state_nxt = C_RUN;
            end
            C_RUN: begin
               if (C_STOP_MODE && w_term_evt) w_state_nxt = C_EXPIRED;
               else if (!go)                  w_state_nxt = C_IDLE;
            end
            C_EXPIRED: begin
               w_state_nxt = C_EXPIRED;
            end
            default: begin
               w_state_nxt = C_IDLE;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // FSM output decode feeding the prescaler and the registered outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_run_en      = (r_state == C_RUN);
      w_running_nxt = (w_state_nxt == C_RUN);
   end

   // ------------------------------------------------------------------------
   // Prescaler: advances only in RUN, so a pause freezes it mid-period
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_presc <= '0;
      end else if (clr || load) begin
         r_presc <= '0;
      end else if (w_run_en) begin
         if (w_tick) r_presc <= '0;
         else        r_presc <= r_presc + C_PRESC_ONE;
      end
   end

   // ------------------------------------------------------------------------
   // Count register with clr > load > tick priority
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_digits <= '0;
      end else if (clr) begin
         r_digits <= '0;
      end else if (load) begin
         r_digits <= w_preset_s;
      end else if (w_cnt_step) begin
         r_digits <= w_cnt_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Lap capture of the pre-edge count; clr wins over a coincident lap
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lap_digits <= '0;
         r_lap_valid  <= 1'b0;
      end else if (clr) begin
         r_lap_digits <= '0;
         r_lap_valid  <= 1'b0;
      end else if (lap) begin
         r_lap_digits <= r_digits;
         r_lap_valid  <= 1'b1;
      end
   end

   // ------------------------------------------------------------------------
   // Registered status outputs: one-cycle done pulse and running flag
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done    <= 1'b0;
         r_running <= 1'b0;
      end else begin
         r_done    <= w_term_evt;
         r_running <= w_running_nxt;
      end
   end

   assign digits     = r_digits;
   assign lap_digits = r_lap_digits;
   assign lap_valid  = r_lap_valid;
   assign done       = r_done;
   assign running    = r_running;

endmodule
`default_nettype wire

// File: tb/tb_bcd_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_timer
//  Description : Self-checking bench for bcd_timer. Instance A is a one-minute
//                -digit wrapping timer, instance B a two-minute-digit timer
//                that stops at its limit; both use a 4-cycle tick.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bcd_timer;

   localparam int DVSR = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   // Instance A: MIN_DIGITS=1, WRAP=1
   logic        go_a = 1'b0, clr_a = 1'b0, load_a = 1'b0, up_a = 1'b1, lap_a = 1'b0;
   logic [15:0] preset_a = '0;
   logic [15:0] digits_a, lap_digits_a;
   logic        lap_valid_a, done_a, running_a;

   // Instance B: MIN_DIGITS=2, WRAP=0
   logic        go_b = 1'b0, clr_b = 1'b0, load_b = 1'b0, up_b = 1'b1, lap_b = 1'b0;
   logic [19:0] preset_b = '0;
   logic [19:0] digits_b, lap_digits_b;
   logic        lap_valid_b, done_b, running_b;

   bcd_timer #(.DVSR(DVSR), .MIN_DIGITS(1), .WRAP(1)) dut_a (
      .clk(clk), .rst_n(rst_n), .go(go_a), .clr(clr_a), .load(load_a),
      .preset(preset_a), .up(up_a), .lap(lap_a), .digits(digits_a),
      .lap_digits(lap_digits_a), .lap_valid(lap_valid_a), .done(done_a),
      .running(running_a)
   );

   bcd_timer #(.DVSR(DVSR), .MIN_DIGITS(2), .WRAP(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .go(go_b), .clr(clr_b), .load(load_b),
      .preset(preset_b), .up(up_b), .lap(lap_b), .digits(digits_b),
      .lap_digits(lap_digits_b), .lap_valid(lap_valid_b), .done(done_b),
      .running(running_b)
   );

   typedef struct {
      logic        clr;
      logic        load;
      logic        lap;
      logic [15:0] preset;
      logic [15:0] exp_digits;
      logic [15:0] exp_lap;
      logic        exp_lv;
   } vec_t;

   typedef struct {
      string       name;
      logic [15:0] digits;
      logic [15:0] lap;
      logic        lv;
   } exp_t;

   vec_t vecs[9];
   exp_t sb[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic sb_push(input string name, input logic [15:0] d, input logic [15:0] l, input logic lv);
      exp_t e;
      e.name = name; e.digits = d; e.lap = l; e.lv = lv;
      sb.push_back(e);
   endtask

   // Pops the oldest expectation and compares it with instance A's outputs.
   task automatic sb_compare();
      exp_t e;
      if (sb.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: got empty queue, expected an entry");
         return;
      end
      e = sb.pop_front();
      check({e.name, "_digits"},    digits_a,     e.digits);
      check({e.name, "_lap_digits"}, lap_digits_a, e.lap);
      check({e.name, "_lap_valid"},  lap_valid_a,  e.lv);
   endtask

   // Runs instance A until n count changes are seen, then drops go.
   task automatic run_ticks_a(input int n, output int first_lat, output int bad_int, output int dones);
      logic [15:0] prev;
      int seen, cyc, since;
      prev = digits_a; seen = 0; cyc = 0; since = 0;
      first_lat = -1; bad_int = 0; dones = 0;
      go_a = 1'b1;
      while (seen < n && cyc < n * DVSR * 2 + 20) begin
         @(negedge clk);
         cyc++; since++;
         if (done_a) dones++;
         if (digits_a !== prev) begin
            if (seen == 0)          first_lat = since;
            else if (since != DVSR) bad_int++;
            seen++; since = 0; prev = digits_a;
         end
      end
      go_a = 1'b0;
      check("tick_count", seen, n);
   endtask

   task automatic load_a_with(input logic [15:0] p, input logic u);
      @(negedge clk);
      load_a = 1'b1; preset_a = p; up_a = u;
      @(negedge clk);
      load_a = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1);
   end

   initial begin
      int lat, bad, dn, cnt, changes;
      logic [15:0] snap;

      //            clr   load  lap   preset    digits    lap       lv
      vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 16'h0C7F, 16'h0579, 16'h0000, 1'b0};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h9599, 16'h0000, 1'b0};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h9599, 16'h9599, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h1234, 16'h1234, 16'h9599, 1'b1};
      vecs[5] = '{1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 16'h0345, 16'h0345, 16'h0000, 1'b0};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 16'h0000, 1'b0};
      vecs[8] = '{1'b0, 1'b1, 1'b0, 16'h9A5B, 16'h9559, 16'h0000, 1'b0};

      // Reset state, during and just after reset
      repeat (3) @(negedge clk);
      check("rst_digits_a",  digits_a,     16'h0);
      check("rst_lap_a",     lap_digits_a, 16'h0);
      check("rst_lv_a",      lap_valid_a,  1'b0);
      check("rst_done_a",    done_a,       1'b0);
      check("rst_running_a", running_a,    1'b0);
      check("rst_digits_b",  digits_b,     20'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_running_a", running_a, 1'b0);

      // Single-cycle operations: clr/load/lap priority and preset clamping
      for (int i = 0; i < 9; i++) begin
         clr_a = vecs[i].clr; load_a = vecs[i].load; lap_a = vecs[i].lap;
         preset_a = vecs[i].preset;
         sb_push($sformatf("vec%0d", i), vecs[i].exp_digits, vecs[i].exp_lap, vecs[i].exp_lv);
         @(negedge clk);
         clr_a = 1'b0; load_a = 1'b0; lap_a = 1'b0;
         sb_compare();
      end

      // Carry chain: 600 ticks from 0.00.0 reach 1.00.0
      @(negedge clk); clr_a = 1'b1; up_a = 1'b1;
      @(negedge clk); clr_a = 1'b0;
      run_ticks_a(600, lat, bad, dn);
      check("carry600_digits",    digits_a, 16'h1000);
      check("carry600_first_lat", lat, DVSR + 1);
      check("carry600_period",    bad, 0);
      check("carry600_done",      dn, 0);

      load_a_with(16'h0099, 1'b1);
      check("load_0099", digits_a, 16'h0099);
      run_ticks_a(1, lat, bad, dn);
      check("carry_0099", digits_a, 16'h0100);
      load_a_with(16'h0599, 1'b1);
      run_ticks_a(1, lat, bad, dn);
      check("carry_0599", digits_a, 16'h1000);
      load_a_with(16'h9599, 1'b1);
      run_ticks_a(1, lat, bad, dn);
      check("wrap_up_digits", digits_a, 16'h0000);
      check("wrap_up_done",   dn, 1);

      // Wrap down: 0.00.1 -> 0.00.0 -> 9.59.9, done only on the wrap
      load_a_with(16'h0001, 1'b0);
      run_ticks_a(1, lat, bad, dn);
      check("down1_digits", digits_a, 16'h0000);
      check("down1_done",   dn, 0);
      run_ticks_a(1, lat, bad, dn);
      check("down2_digits", digits_a, 16'h9599);
      check("down2_done",   dn, 1);

      // Lap on a tick edge captures the pre-tick count
      load_a_with(16'h0123, 1'b1);
      go_a = 1'b1;
      repeat (4) @(negedge clk);
      check("lap_pre_digits", digits_a, 16'h0123);
      lap_a = 1'b1;
      sb_push("lap_tick", 16'h0124, 16'h0123, 1'b1);
      @(negedge clk);
      lap_a = 1'b0; go_a = 1'b0;
      sb_compare();
      @(negedge clk);
      clr_a = 1'b1;
      sb_push("lap_clr", 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      clr_a = 1'b0;
      sb_compare();

      // Pause after two run cycles, resume: two more run cycles to the tick
      up_a = 1'b1;
      go_a = 1'b1;
      repeat (2) @(negedge clk);
      check("pause_running", running_a, 1'b1);
      go_a = 1'b0;
      repeat (50) @(negedge clk);
      check("paused_running", running_a, 1'b0);
      check("paused_digits",  digits_a,  16'h0000);
      go_a = 1'b1;
      cnt = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (digits_a !== 16'h0000) break;
         if (running_a) cnt++;
      end
      go_a = 1'b0;
      check("resume_run_cycles", cnt, 2);
      check("resume_digits",     digits_a, 16'h0001);

      // Stop at limit (instance B): 00.00.2 down to 0, then EXPIRED
      @(negedge clk); load_b = 1'b1; preset_b = 20'h00002; up_b = 1'b0;
      @(negedge clk); load_b = 1'b0; go_b = 1'b1;
      check("b_load", digits_b, 20'h00002);
      repeat (8) @(negedge clk);
      check("b_tick1_digits",  digits_b,  20'h00001);
      check("b_tick1_done",    done_b,    1'b0);
      @(negedge clk);
      check("b_limit_digits",  digits_b,  20'h00000);
      check("b_limit_done",    done_b,    1'b1);
      check("b_limit_running", running_b, 1'b0);
      @(negedge clk);
      check("b_done_width",    done_b,    1'b0);
      changes = 0;
      for (int k = 0; k < 10 * DVSR; k++) begin
         @(negedge clk);
         if (digits_b !== 20'h0 || done_b || running_b) changes++;
      end
      check("b_expired_hold", changes, 0);
      load_b = 1'b1; preset_b = 20'h12345;
      @(negedge clk);
      load_b = 1'b0;
      check("b_reload_digits",  digits_b,  20'h12345);
      check("b_reload_running", running_b, 1'b0);
      @(negedge clk);
      check("b_idle_to_run",    running_b, 1'b1);
      go_b = 1'b0;

      // Stop at limit when already at terminal: done, count unchanged
      @(negedge clk); load_b = 1'b1; preset_b = 20'h00000; up_b = 1'b0;
      @(negedge clk); load_b = 1'b0; go_b = 1'b1;
      repeat (DVSR + 1) @(negedge clk);
      check("b_at_term_done",    done_b,    1'b1);
      check("b_at_term_digits",  digits_b,  20'h00000);
      check("b_at_term_running", running_b, 1'b0);
      go_b = 1'b0; clr_b = 1'b1;
      @(negedge clk); clr_b = 1'b0;

      // Asynchronous reset mid-run
      load_a_with(16'h0345, 1'b1);
      lap_a = 1'b1;
      @(negedge clk);
      lap_a = 1'b0; go_a = 1'b1;
      repeat (6) @(negedge clk);
      snap = digits_a;
      check("pre_rst_running", running_a,   1'b1);
      check("pre_rst_lv",      lap_valid_a, 1'b1);
      check("pre_rst_digits",  snap,        16'h0346);
      #2 rst_n = 1'b0;
      #1;
      check("arst_digits",  digits_a,     16'h0);
      check("arst_lap",     lap_digits_a, 16'h0);
      check("arst_lv",      lap_valid_a,  1'b0);
      check("arst_done",    done_a,       1'b0);
      check("arst_running", running_a,    1'b0);
      go_a = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
